// File: rtl/pseudo_cpu_top.sv
// Minimal accumulator-style CPU: 8-bit instructions fetched from a small imem,
// operating on data registers a, b and result register r with a zero flag z.
package pseudo_cpu_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_SUB   = 4'h1,
        OP_ADD   = 4'h2,
        OP_XOR   = 4'h3,
        OP_TSTA  = 4'h4,
        OP_JZ    = 4'h5,
        OP_JNZ   = 4'h6,
        OP_JMP   = 4'h7,
        OP_SETR  = 4'h8,
        OP_MOVAR = 4'h9,
        OP_HALT  = 4'hF
    } op_e;
endpackage

// Control path: instruction memory, program counter and run/halted state.
module pseudo_cpu_ctrl
    import pseudo_cpu_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       z,
    output logic [7:0] instr,
    output logic       halted
);
    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    // NOTE: imem has no reset and no write port; contents come from a file-based
    // binary memory init or a hierarchical load and must survive a core reset.
    logic [7:0]        imem [2**ADDR_W];
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] target;
    op_e               op;
    state_e            state_q;

    assign instr  = imem[addr];
    assign op     = op_e'(instr[7:4]);
    assign target = ADDR_W'(instr[3:0]);
    assign halted = (state_q == ST_HALTED);

    // NOTE: the default assignment up front keeps addr_d from becoming a latch.
    always_comb begin
        addr_d = addr + ADDR_W'(1);
        case (op)
            OP_JZ:   if (z)  addr_d = target;
            OP_JNZ:  if (!z) addr_d = target;
            OP_JMP:  addr_d = target;
            OP_HALT: addr_d = addr;
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr    <= '0;
            state_q <= ST_RUN;
        end else if (en && state_q == ST_RUN) begin
            addr <= addr_d;
            if (op == OP_HALT) state_q <= ST_HALTED;
        end
    end
endmodule

module pseudo_cpu_top
    import pseudo_cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              done,
    output logic [DATA_W-1:0] res
);
    logic [7:0]        instr;
    logic              halted;
    logic              step;
    op_e               op;
    logic [DATA_W-1:0] a, b, r, z_unused_pad;
    logic [DATA_W-1:0] a_d, r_d;
    logic [DATA_W-1:0] sum, diff, xr;
    logic              z, z_d;

    pseudo_cpu_ctrl #(.ADDR_W(ADDR_W)) ctrl (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .z      (z),
        .instr  (instr),
        .halted (halted)
    );

    assign op   = op_e'(instr[7:4]);
    assign step = en && !halted;
    assign sum  = a + b;
    assign diff = a - b;
    assign xr   = a ^ b;
    assign done = halted;
    assign res  = r;
    assign z_unused_pad = '0;

    always_comb begin
        a_d = a;
        r_d = r;
        z_d = z;
        case (op)
            OP_SUB:   begin a_d = diff; z_d = (diff == '0); end
            OP_ADD:   begin a_d = sum;  z_d = (sum == '0);  end
            OP_XOR:   begin a_d = xr;   z_d = (xr == '0);   end
            OP_TSTA:  z_d = (a == '0);
            OP_SETR:  r_d = DATA_W'(instr[3:0]);
            OP_MOVAR: r_d = a;
            default:  ;
        endcase
    end

    // Plain always rather than always_ff: a and b also receive hierarchical
    // deposits from outside this process while the core is stopped.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a <= '0;
            b <= '0;
        end else if (step) begin
            a <= a_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
            z <= 1'b0;
        end else if (step) begin
            r <= r_d;
            z <= z_d;
        end
    end
endmodule

// File: tb/tb_pseudo_cpu_top.sv
// Directed-program bench: each program pushes its expected result and halt
// latency to a scoreboard that a monitor checks when done rises.
module tb_pseudo_cpu_top;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef logic [7:0] prog_t [16];
    typedef struct {
        logic [DATA_W-1:0] res;
        int                edges;
        string             name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              done;
    logic [DATA_W-1:0] res;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt;
    bit   done_seen = 1'b0;

    pseudo_cpu_top #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .done (done),
        .res  (res)
    );

    always #5 clk = ~clk;

    // Executed instructions since the last reset (edges with en=1 before halt).
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else if (en && !done) edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !done_seen) begin
                done_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no halt");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_res"}, res, e.res);
                    check({e.name, "_edges"}, edge_cnt, e.edges);
                end
            end else if (!done) begin
                done_seen = 1'b0;
            end
        end
    end

    task automatic do_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_prog(input prog_t p, input logic [DATA_W-1:0] av,
                              input logic [DATA_W-1:0] bv);
        do_reset();
        for (int i = 0; i < 16; i++) dut.ctrl.imem[i] = p[i];
        dut.a <= av;
        dut.b <= bv;
        @(negedge clk);
    endtask

    task automatic expect_halt(input string name, input logic [DATA_W-1:0] r_exp, input int edges);
        exp_t e;
        e.res   = r_exp;
        e.edges = edges;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 64 && !done; i++) @(negedge clk);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 64 cycles", name);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_prog(input string name, input prog_t p, input logic [DATA_W-1:0] av,
                            input logic [DATA_W-1:0] bv, input logic [DATA_W-1:0] r_exp,
                            input int edges);
        start_prog(p, av, bv);
        expect_halt(name, r_exp, edges);
        en = 1'b1;
        wait_done(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Asynchronous reset before any clock edge.
        #3 rst = 1'b0;
        #1;
        check("reset_done", done, 0);
        check("reset_res", res, 0);
        check("reset_addr", dut.ctrl.addr, 0);
        #10 rst = 1'b1;

        // XOR of unequal operands: JZ falls through to SETR 0, halts at 3.
        run_prog("xor_ne", '{0:8'h30, 1:8'h54, 2:8'h80, 3:8'hF0, 4:8'h81, 5:8'hF0, default:8'hF0},
                 32'd4123481, 32'd9402102, 32'd0, 4);
        // Halted: further edges with en=1 must change nothing.
        repeat (5) @(negedge clk);
        check("halt_hold_addr", dut.ctrl.addr, 3);
        check("halt_hold_done", done, 1);
        check("halt_hold_a", dut.a, 32'd4123481 ^ 32'd9402102);
        check("halt_hold_res", res, 0);

        // Equal operands: z=1, JZ taken to SETR 1 then HALT (still 4 instructions).
        run_prog("xor_eq", '{0:8'h30, 1:8'h54, 2:8'h80, 3:8'hF0, 4:8'h81, 5:8'hF0, default:8'hF0},
                 32'd4123481, 32'd4123481, 32'd1, 4);
        check("xor_eq_z", dut.z, 1);

        // 5 - 7 wraps modulo 2**32.
        run_prog("sub_wrap", '{0:8'h10, 1:8'h90, 2:8'hF0, default:8'hF0},
                 32'd5, 32'd7, 32'hFFFF_FFFE, 3);
        check("sub_wrap_b", dut.b, 7);

        // ADD to zero, JNZ not taken, op A as NOP, TSTA, JZ taken past SETR 1, SETR 12.
        run_prog("mix", '{0:8'h20, 1:8'h67, 2:8'hA0, 3:8'h40, 4:8'h56, 5:8'h81, 6:8'h8C, 7:8'hF0,
                          default:8'hF0},
                 32'd3, 32'hFFFF_FFFD, 32'd12, 7);
        check("mix_a", dut.a, 0);

        // PC wrap: JNZ 3, XOR (z=1), JMP 15, NOP at 15 wraps to 0, JNZ falls to HALT.
        start_prog('{0:8'h63, 1:8'hF0, 3:8'h30, 4:8'h7F, 15:8'h00, default:8'hF0}, 32'd0, 32'd0);
        expect_halt("wrap", 32'd0, 6);
        en = 1'b1;
        repeat (4) @(negedge clk);
        check("wrap_addr", dut.ctrl.addr, 0);
        wait_done("wrap");

        // en held low: nothing moves, bench-written a/b persist, then run normally.
        start_prog('{0:8'h10, 1:8'h90, 2:8'hF0, default:8'hF0}, 32'h1234, 32'h5678);
        repeat (100) @(negedge clk);
        check("en0_addr", dut.ctrl.addr, 0);
        check("en0_done", done, 0);
        check("en0_a", dut.a, 32'h1234);
        check("en0_b", dut.b, 32'h5678);
        expect_halt("en0_run", 32'hFFFF_BBBC, 3);
        en = 1'b1;
        wait_done("en0_run");

        // Mid-program reset: SUB, MOVAR, then spin on JMP 2.
        start_prog('{0:8'h10, 1:8'h90, 2:8'h72, default:8'hF0}, 32'd5, 32'd7);
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("spin_res", res, 32'hFFFF_FFFE);
        check("spin_addr", dut.ctrl.addr, 2);
        #2 rst = 1'b0;
        #1;
        check("arst_addr", dut.ctrl.addr, 0);
        check("arst_a", dut.a, 0);
        check("arst_b", dut.b, 0);
        check("arst_res", res, 0);
        check("arst_z", dut.z, 0);
        check("arst_done", done, 0);
        repeat (2) @(negedge clk);
        check("arst_hold_addr", dut.ctrl.addr, 0);
        en = 1'b0;
        rst = 1'b1;
        dut.a <= 32'd5;
        dut.b <= 32'd7;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("restart_addr", dut.ctrl.addr, 1);
        check("restart_a", dut.a, 32'hFFFF_FFFE);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
